// File: rtl/conv_input_loader.sv
// rtl/conv_input_loader.sv - assembles a pixel-beat stream into channel planes and hands them to the conv core
module conv_input_loader #(
    parameter int IC          = 8,
    parameter int IMG_IN_SIZE = 30
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 pix_valid,
    output logic                                 pix_ready,
    input  logic [IC-1:0]                        pix_data,
    input  logic                                 pix_last,
    output logic [IMG_IN_SIZE*IMG_IN_SIZE-1:0]   img_in [0:IC-1],
    output logic                                 data_in_ready,
    input  logic                                 conv_done,
    output logic                                 frame_err,
    output logic [15:0]                          frame_count
);
    localparam int NPIX  = IMG_IN_SIZE * IMG_IN_SIZE;
    localparam int IDX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPIX - 1);

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        HOLD    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [NPIX-1:0]     img_q [0:IC-1];
    logic [NPIX-1:0]     img_d [0:IC-1];
    logic                pix_ready_q, pix_ready_d;
    logic                data_in_ready_q, data_in_ready_d;
    logic                frame_err_q, frame_err_d;
    logic [15:0]         frame_count_q, frame_count_d;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        img_d         = img_q;
        frame_err_d   = frame_err_q;
        frame_count_d = frame_count_q;

        case (state_q)
            LOAD: begin
                if (pix_valid) begin
                    for (int c = 0; c < IC; c++) begin
                        img_d[c][idx_q] = pix_data[c];
                    end
                    // Any frame boundary restarts the beat counter; only a well-formed one is handed off.
                    if (idx_q == LAST_IDX || pix_last) begin
                        idx_d = '0;
                        if (idx_q == LAST_IDX && pix_last) begin
                            state_d = HOLD;
                        end else begin
                            frame_err_d = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            HOLD: begin
                if (conv_done) begin
                    state_d       = RELEASE;
                    frame_count_d = frame_count_q + 16'd1;
                end
            end
            RELEASE: begin
                state_d = LOAD;
            end
            default: begin
                state_d = LOAD;
            end
        endcase

        pix_ready_d     = (state_d == LOAD);
        data_in_ready_d = (state_d == HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= LOAD;
            idx_q           <= '0;
            pix_ready_q     <= 1'b1;
            data_in_ready_q <= 1'b0;
            frame_err_q     <= 1'b0;
            frame_count_q   <= '0;
            for (int c = 0; c < IC; c++) begin
                img_q[c] <= '0;
            end
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            pix_ready_q     <= pix_ready_d;
            data_in_ready_q <= data_in_ready_d;
            frame_err_q     <= frame_err_d;
            frame_count_q   <= frame_count_d;
            for (int c = 0; c < IC; c++) begin
                img_q[c] <= img_d[c];
            end
        end
    end

    assign pix_ready     = pix_ready_q;
    assign data_in_ready = data_in_ready_q;
    assign frame_err     = frame_err_q;
    assign frame_count   = frame_count_q;
    assign img_in        = img_q;

endmodule

// File: tb/tb_conv_input_loader.sv
// tb/tb_conv_input_loader.sv - directed bench for conv_input_loader (IC=2, 4x4 image)
module tb_conv_input_loader;
    localparam int IC  = 2;
    localparam int SZ  = 4;
    localparam int NPIX = SZ * SZ;

    logic              clk;
    logic              rst;
    logic              pix_valid;
    logic              pix_ready;
    logic [IC-1:0]     pix_data;
    logic              pix_last;
    logic [NPIX-1:0]   img_in [0:IC-1];
    logic              data_in_ready;
    logic              conv_done;
    logic              frame_err;
    logic [15:0]       frame_count;

    int n_chk;
    int n_fail;

    conv_input_loader #(.IC(IC), .IMG_IN_SIZE(SZ)) dut (
        .clk           (clk),
        .rst           (rst),
        .pix_valid     (pix_valid),
        .pix_ready     (pix_ready),
        .pix_data      (pix_data),
        .pix_last      (pix_last),
        .img_in        (img_in),
        .data_in_ready (data_in_ready),
        .conv_done     (conv_done),
        .frame_err     (frame_err),
        .frame_count   (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] plane1;
        logic [15:0] plane0;
        logic [15:0] gaps;
        logic [15:0] exp_img1;
        logic [15:0] exp_img0;
        logic [15:0] exp_count;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge, so each rising edge sees a stable beat.
    task automatic send_beats(input logic [15:0] p1, input logic [15:0] p0,
                              input logic [15:0] gaps, input int nbeats, input int last_at);
        for (int k = 0; k < nbeats; k++) begin
            if (gaps[k]) begin
                pix_valid = 1'b0;
                pix_data  = 2'b11;
                @(negedge clk);
            end
            pix_valid = 1'b1;
            pix_data  = {p1[k], p0[k]};
            pix_last  = (k == last_at);
            @(negedge clk);
        end
        pix_valid = 1'b0;
        pix_last  = 1'b0;
    endtask

    task automatic handshake(input logic [15:0] exp_count);
        conv_done = 1'b1;
        @(negedge clk);
        conv_done = 1'b0;
        chk("release_dir", {31'd0, data_in_ready}, 32'd0);
        chk("release_count", {16'd0, frame_count}, {16'd0, exp_count});
        chk("release_ready", {31'd0, pix_ready}, 32'd0);
        @(negedge clk);
        chk("reload_ready", {31'd0, pix_ready}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, {31'd0, pix_ready}, 32'd1);
        chk({tag, "_dir"}, {31'd0, data_in_ready}, 32'd0);
        chk({tag, "_err"}, {31'd0, frame_err}, 32'd0);
        chk({tag, "_count"}, {16'd0, frame_count}, 32'd0);
        chk({tag, "_img0"}, {16'd0, img_in[0]}, 32'd0);
        chk({tag, "_img1"}, {16'd0, img_in[1]}, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    vec_t vecs [4];

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        rst       = 1'b1;
        pix_valid = 1'b0;
        pix_data  = '0;
        pix_last  = 1'b0;
        conv_done = 1'b0;

        vecs[0] = '{16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'd1};
        vecs[1] = '{16'hA5A5, 16'h0F0F, 16'h1234, 16'hA5A5, 16'h0F0F, 16'd2};
        vecs[2] = '{16'h0001, 16'h8000, 16'hFFFF, 16'h0001, 16'h8000, 16'd3};
        vecs[3] = '{16'h0000, 16'hFFFF, 16'h5A5A, 16'h0000, 16'hFFFF, 16'd4};

        repeat (2) @(negedge clk);
        check_reset_outputs("in_reset");
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", {31'd0, pix_ready}, 32'd1);

        for (int i = 0; i < 4; i++) begin
            send_beats(vecs[i].plane1, vecs[i].plane0, vecs[i].gaps, NPIX, NPIX - 1);
            chk($sformatf("v%0d_dir", i), {31'd0, data_in_ready}, 32'd1);
            chk($sformatf("v%0d_ready", i), {31'd0, pix_ready}, 32'd0);
            chk($sformatf("v%0d_img1", i), {16'd0, img_in[1]}, {16'd0, vecs[i].exp_img1});
            chk($sformatf("v%0d_img0", i), {16'd0, img_in[0]}, {16'd0, vecs[i].exp_img0});
            // Beats offered during HOLD must be dropped.
            for (int j = 0; j < 3; j++) begin
                pix_valid = 1'b1;
                pix_data  = 2'(j + 1);
                pix_last  = j[0];
                @(negedge clk);
            end
            pix_valid = 1'b0;
            pix_last  = 1'b0;
            chk($sformatf("v%0d_hold_img1", i), {16'd0, img_in[1]}, {16'd0, vecs[i].exp_img1});
            chk($sformatf("v%0d_hold_img0", i), {16'd0, img_in[0]}, {16'd0, vecs[i].exp_img0});
            chk($sformatf("v%0d_hold_dir", i), {31'd0, data_in_ready}, 32'd1);
            handshake(vecs[i].exp_count);
        end
        chk("no_err_clean", {31'd0, frame_err}, 32'd0);

        // Sixteen beats without pix_last: discarded and flagged.
        do_reset();
        send_beats(16'hFFFF, 16'hFFFF, 16'h0000, NPIX, -1);
        chk("errB_err", {31'd0, frame_err}, 32'd1);
        chk("errB_dir", {31'd0, data_in_ready}, 32'd0);
        chk("errB_ready", {31'd0, pix_ready}, 32'd1);

        // Early pix_last on beat 9, then a fresh frame starting from idx 0.
        do_reset();
        send_beats(16'h0000, 16'h0000, 16'h0000, 10, 9);
        chk("errA_err", {31'd0, frame_err}, 32'd1);
        chk("errA_dir", {31'd0, data_in_ready}, 32'd0);
        chk("errA_ready", {31'd0, pix_ready}, 32'd1);
        send_beats(16'h0001, 16'h0001, 16'h0000, NPIX, NPIX - 1);
        chk("errA_next_dir", {31'd0, data_in_ready}, 32'd1);
        chk("errA_next_img1", {16'd0, img_in[1]}, 32'h0001);
        chk("errA_next_img0", {16'd0, img_in[0]}, 32'h0001);
        chk("errA_sticky", {31'd0, frame_err}, 32'd1);
        handshake(16'd1);

        // Reset after beat 7 while a beat is still being offered.
        send_beats(16'hFFFF, 16'hFFFF, 16'h0000, 8, -1);
        rst       = 1'b1;
        pix_valid = 1'b1;
        pix_data  = 2'b11;
        @(negedge clk);
        rst       = 1'b0;
        pix_valid = 1'b0;
        check_reset_outputs("rst_mid");
        send_beats(16'h00F0, 16'h0F00, 16'h0000, NPIX, NPIX - 1);
        chk("rst_mid_frame_dir", {31'd0, data_in_ready}, 32'd1);
        chk("rst_mid_frame_img1", {16'd0, img_in[1]}, 32'h00F0);
        chk("rst_mid_frame_img0", {16'd0, img_in[0]}, 32'h0F00);
        handshake(16'd1);

        // Reset during HOLD with conv_done asserted at the same edge.
        send_beats(16'h3C3C, 16'hC3C3, 16'h0000, NPIX, NPIX - 1);
        chk("rst_hold_pre_dir", {31'd0, data_in_ready}, 32'd1);
        rst       = 1'b1;
        conv_done = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        conv_done = 1'b0;
        check_reset_outputs("rst_hold");
        send_beats(16'h8001, 16'h7FFE, 16'h0000, NPIX, NPIX - 1);
        chk("rst_hold_frame_dir", {31'd0, data_in_ready}, 32'd1);
        chk("rst_hold_frame_img1", {16'd0, img_in[1]}, 32'h8001);
        handshake(16'd1);

        // Counter wrap.
        force dut.frame_count_q = 16'hFFFF;
        @(negedge clk);
        release dut.frame_count_q;
        @(negedge clk);
        chk("wrap_preset", {16'd0, frame_count}, 32'hFFFF);
        send_beats(16'h1111, 16'h2222, 16'h0000, NPIX, NPIX - 1);
        chk("wrap_dir", {31'd0, data_in_ready}, 32'd1);
        handshake(16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
